fir_transposed_param: RTL and testbench

Parametrised transposed-form FIR filter: the next generation of the team's 10-tap fixed-coefficient transposed FIR. Adds configurable data, coefficient and tap widths, a runtime-loadable double-buffered coefficient bank, rounding with an output scale shift, optional saturation, a warm-up indicator and a synchronous flush. Sits in the sample-rate datapath between the 300 kHz sample strobe source and downstream sample consumers, all on the 12 MHz clock.

---
 rtl/fir_transposed_param.sv | 174 +++++++++++++++++
 tb/tb_fir_transposed_param.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_transposed_param.sv
// fir_transposed_param
// Parametrised transposed-form FIR filter with a double-buffered, runtime
// loadable coefficient bank, round-half-up output scaling, warm-up indicator
// and synchronous flush. All logic runs on the rising edge of iClk_12M and
// advances only on cycles where iEnSample_300k is high.
// Build option: define FIR_SAT_EN to clamp the scaled output to the DATA_W
// range and report clipping on oSat; otherwise the output wraps and oSat is 0.
module fir_transposed_param #(
   parameter int DATA_W    = 16,
   parameter int COEF_W    = 16,
   parameter int TAPS      = 10,
   parameter int OUT_SHIFT = 15
) (
   input  logic                      iClk_12M,
   input  logic                      iRst,
   input  logic                      iEnSample_300k,
   input  logic signed [DATA_W-1:0]  iFirIn,
   input  logic                      iFlush,
   input  logic                      iCoeffWe,
   input  logic [$clog2(TAPS)-1:0]   iCoeffAddr,
   input  logic signed [COEF_W-1:0]  iCoeffData,
   input  logic                      iCoeffCommit,
   output logic signed [DATA_W-1:0]  oMac,
   output logic                      oValid,
   output logic                      oFull,
   output logic                      oSat,
   output logic                      oCommitPend
);

   // Accumulator carries log2(TAPS) guard bits so the full sum never overflows.
   localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS);
   localparam int CNT_W = $clog2(TAPS + 1);
   localparam logic signed [ACC_W-1:0] RND_C = ACC_W'(1) << (OUT_SHIFT - 1);
   localparam logic [CNT_W-1:0]        CNT_FULL = CNT_W'(TAPS);

   // Coefficient banks: shadow is written by the host, active feeds the multipliers.
   logic signed [COEF_W-1:0] shadow_q [TAPS];
   logic signed [COEF_W-1:0] shadow_d [TAPS];
   logic signed [COEF_W-1:0] active_q [TAPS];
   logic signed [COEF_W-1:0] active_d [TAPS];

   // Transposed partial sums; tap 0 feeds the output directly and needs no register.
   logic signed [ACC_W-1:0]  acc_q [1:TAPS-1];
   logic signed [ACC_W-1:0]  acc_d [1:TAPS-1];

   logic                     pend_q, pend_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic signed [DATA_W-1:0] mac_q, mac_d;
   logic                     valid_q, valid_d;
   logic                     sat_q, sat_d;

   // Combinational datapath intermediates.
   logic signed [ACC_W-1:0]  prod [TAPS];
   logic signed [ACC_W-1:0]  sum;
   logic signed [ACC_W-1:0]  sum_rnd;
   logic signed [ACC_W-1:0]  rnd;
   logic signed [DATA_W-1:0] mac_new;
   logic                     sat_new;
   logic                     strobe;
`ifndef FIR_SAT_EN
   logic                     unused_rnd_hi;
`endif

   // Products, transposed accumulation, output scaling and coefficient bank control.
   always_comb begin
      // NOTE: every next-state value takes its hold value first, so no path can infer a latch.
      shadow_d = shadow_q;
      active_d = active_q;
      acc_d    = acc_q;
      pend_d   = pend_q;
      cnt_d    = cnt_q;
      mac_d    = mac_q;
      sat_d    = sat_q;
      valid_d  = 1'b0;

      // A flush in the same cycle as a strobe drops the sample.
      strobe = iEnSample_300k & ~iFlush;

      for (int k = 0; k < TAPS; k++) begin
         prod[k] = ACC_W'(active_q[k]) * ACC_W'(iFirIn);
      end

      sum     = prod[0] + acc_q[1];
      sum_rnd = sum + RND_C;
      rnd     = sum_rnd >>> OUT_SHIFT;

`ifdef FIR_SAT_EN
      if (rnd > ACC_W'({1'b0, {(DATA_W-1){1'b1}}})) begin
         mac_new = {1'b0, {(DATA_W-1){1'b1}}};
         sat_new = 1'b1;
      end else if (rnd < -ACC_W'({1'b0, {(DATA_W-1){1'b1}}}) - ACC_W'(1)) begin
         mac_new = {1'b1, {(DATA_W-1){1'b0}}};
         sat_new = 1'b1;
      end else begin
         mac_new = rnd[DATA_W-1:0];
         sat_new = 1'b0;
      end
`else
      // Two's-complement wrap: the upper bits of the scaled sum are discarded.
      mac_new       = rnd[DATA_W-1:0];
      sat_new       = 1'b0;
      unused_rnd_hi = ^rnd[ACC_W-1:DATA_W];
`endif

      // Shadow writes outside the tap range are dropped.
      if (iCoeffWe && (32'(iCoeffAddr) < 32'(TAPS))) begin
         shadow_d[iCoeffAddr] = iCoeffData;
      end

      if (iFlush) begin
         acc_d = '{default: '0};
         cnt_d = '0;
         mac_d = '0;
      end else if (iEnSample_300k) begin
         acc_d[TAPS-1] = prod[TAPS-1];
         for (int k = 1; k < TAPS - 1; k++) begin
            acc_d[k] = prod[k] + acc_q[k+1];
         end
         if (cnt_q != CNT_FULL) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         mac_d   = mac_new;
         sat_d   = sat_new;
         valid_d = 1'b1;
         // This strobe still multiplies with the old bank; the swap lands at the edge.
         if (pend_q) begin
            active_d = shadow_q;
         end
      end

      // A commit only arms the swap; further commits while armed change nothing.
      if (strobe && pend_q) begin
         pend_d = 1'b0;
      end else if (iCoeffCommit) begin
         pend_d = 1'b1;
      end
   end

   // State register with synchronous reset that overrides every input.
   always_ff @(posedge iClk_12M) begin
      if (iRst) begin
         // NOTE: both coefficient banks are cleared on reset so the filter restarts with all-zero taps.
         for (int k = 0; k < TAPS; k++) begin
            shadow_q[k] <= '0;
            active_q[k] <= '0;
         end
         for (int k = 1; k < TAPS; k++) begin
            acc_q[k] <= '0;
         end
         pend_q  <= 1'b0;
         cnt_q   <= '0;
         mac_q   <= '0;
         valid_q <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from pre-edge values.
         shadow_q <= shadow_d;
         active_q <= active_d;
         acc_q    <= acc_d;
         pend_q   <= pend_d;
         cnt_q    <= cnt_d;
         mac_q    <= mac_d;
         valid_q  <= valid_d;
         sat_q    <= sat_d;
      end
   end

   assign oMac        = mac_q;
   assign oValid      = valid_q;
   assign oFull       = (cnt_q == CNT_FULL);
   assign oSat        = sat_q;
   assign oCommitPend = pend_q;

endmodule

// File: tb/tb_fir_transposed_param.sv
// tb_fir_transposed_param
// Self-checking bench for fir_transposed_param (default parameters). Expected
// outputs come from stimulus tables and hand-derived sequences, are queued when
// a strobe is driven and compared when oValid appears.
module tb_fir_transposed_param;

   localparam int DATA_W    = 16;
   localparam int COEF_W    = 16;
   localparam int TAPS      = 10;
   localparam int OUT_SHIFT = 15;
   localparam int AW        = $clog2(TAPS);

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     en;
   logic signed [DATA_W-1:0] x;
   logic                     flush;
   logic                     we;
   logic [AW-1:0]            addr;
   logic signed [COEF_W-1:0] cdata;
   logic                     commit;
   logic signed [DATA_W-1:0] mac;
   logic                     valid;
   logic                     full;
   logic                     sat;
   logic                     pend;

   typedef struct packed {
      logic signed [DATA_W-1:0] mac;
      logic                     sat;
   } exp_t;

   typedef struct {
      logic signed [DATA_W-1:0] x;
      logic signed [DATA_W-1:0] mac;
      logic                     full;
   } vec_t;

   exp_t exp_q [$];
   int   n_checks = 0;
   int   n_err    = 0;

   always #5 clk = ~clk;

   fir_transposed_param #(
      .DATA_W    (DATA_W),
      .COEF_W    (COEF_W),
      .TAPS      (TAPS),
      .OUT_SHIFT (OUT_SHIFT)
   ) dut (
      .iClk_12M       (clk),
      .iRst           (rst),
      .iEnSample_300k (en),
      .iFirIn         (x),
      .iFlush         (flush),
      .iCoeffWe       (we),
      .iCoeffAddr     (addr),
      .iCoeffData     (cdata),
      .iCoeffCommit   (commit),
      .oMac           (mac),
      .oValid         (valid),
      .oFull          (full),
      .oSat           (sat),
      .oCommitPend    (pend)
   );

   task automatic check(input string name, input longint act, input longint expv);
      n_checks++;
      if (act != expv) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   // One clock; outputs sampled 1 time unit after the edge. oValid must follow the
   // strobe just driven, and every pulse is matched against the scoreboard head.
   task automatic tick();
      logic exp_v;
      exp_t e;
      exp_v = en && !flush && !rst;
      @(posedge clk);
      #1;
      check("valid", valid, exp_v);
      if (valid) begin
         check("sb_has_entry", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("mac", mac, e.mac);
            check("sat", sat, e.sat);
         end
      end
   endtask

   task automatic strobe(input logic signed [DATA_W-1:0] xv,
                         input logic signed [DATA_W-1:0] m,
                         input logic s);
      exp_t e;
      e.mac = m;
      e.sat = s;
      exp_q.push_back(e);
      en = 1'b1;
      x  = xv;
      tick();
      en = 1'b0;
      x  = '0;
   endtask

   task automatic write_shadow(input int k, input int v);
      we    = 1'b1;
      addr  = AW'(k);
      cdata = COEF_W'(v);
      tick();
      we    = 1'b0;
   endtask

   // Commit, clear history, spend one zero-sample strobe on the swap, clear again.
   task automatic swap_in();
      commit = 1'b1;
      tick();
      commit = 1'b0;
      check("pend_after_commit", pend, 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      strobe(0, 0, 1'b0);
      check("pend_after_swap", pend, 0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   // Sustained full-scale input with all coefficients 32767: n-th strobe after a flush.
   function automatic exp_t sat_run(input int n, input bit neg);
      exp_t   e;
      longint v;
      v = neg ? -longint'(32767) * n : longint'(32766) * n;
`ifdef FIR_SAT_EN
      if (n == 1) begin
         e.mac = DATA_W'(v);
         e.sat = 1'b0;
      end else begin
         e.mac = neg ? -16'sd32768 : 16'sd32767;
         e.sat = 1'b1;
      end
`else
      e.mac = DATA_W'(v);
      e.sat = 1'b0;
`endif
      return e;
   endfunction

   initial begin
      vec_t imp_tab [12];
      vec_t rnd_tab [4];
      exp_t e;

      // Impulse: x=32 then zeros; c[k]=(k+1)*1024 gives k+1 per strobe.
      for (int i = 0; i < 12; i++) begin
         imp_tab[i].x    = (i == 0) ? 16'sd32 : 16'sd0;
         imp_tab[i].mac  = (i < 10) ? DATA_W'(i + 1) : 16'sd0;
         imp_tab[i].full = (i >= 9);
      end
      // c[0]=16384 (0.5): round half up on the >>>15.
      rnd_tab[0] = '{x: 16'sd1000, mac: 16'sd500, full: 1'b0};
      rnd_tab[1] = '{x: -16'sd3,   mac: -16'sd1,  full: 1'b0};
      rnd_tab[2] = '{x: 16'sd1,    mac: 16'sd1,   full: 1'b0};
      rnd_tab[3] = '{x: -16'sd1,   mac: 16'sd0,   full: 1'b0};

      rst = 1'b1; en = 1'b0; x = '0; flush = 1'b0;
      we = 1'b0; addr = '0; cdata = '0; commit = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst_mac", mac, 0);
      check("rst_full", full, 0);
      check("rst_sat", sat, 0);
      check("rst_pend", pend, 0);
      rst = 1'b0;

      // Impulse response
      for (int k = 0; k < TAPS; k++) write_shadow(k, (k + 1) * 1024);
      swap_in();
      for (int i = 0; i < 12; i++) begin
         strobe(imp_tab[i].x, imp_tab[i].mac, 1'b0);
         check("imp_full", full, imp_tab[i].full);
      end

      // Flush colliding with a strobe mid-stream
      strobe(32, 1, 1'b0);
      strobe(32, 3, 1'b0);
      strobe(32, 6, 1'b0);
      check("full_before_flush", full, 1);
      en = 1'b1; x = 16'sd32; flush = 1'b1;
      tick();
      en = 1'b0; x = '0; flush = 1'b0;
      check("flush_mac", mac, 0);
      check("flush_full", full, 0);
      strobe(32, 1, 1'b0);
      strobe(0, 2, 1'b0);
      check("post_flush_full", full, 0);

      // Scaling and rounding
      write_shadow(0, 16384);
      for (int k = 1; k < TAPS; k++) write_shadow(k, 0);
      swap_in();
      for (int i = 0; i < 4; i++) begin
         strobe(rnd_tab[i].x, rnd_tab[i].mac, 1'b0);
         check("rnd_full", full, rnd_tab[i].full);
      end

      // Commit boundary: commit with a strobe, swap on the next strobe
      we = 1'b1; addr = '0; cdata = 16'sd32767; commit = 1'b1;
      strobe(1000, 500, 1'b0);
      we = 1'b0; commit = 1'b0;
      check("pend_armed", pend, 1);
      tick();
      check("pend_gap", pend, 1);
      check("mac_hold", mac, 500);
      tick();
      check("pend_gap2", pend, 1);
      // A shadow write in the swap cycle is not part of this swap.
      we = 1'b1; addr = '0; cdata = 16'sd0;
      strobe(1000, 500, 1'b0);
      we = 1'b0;
      check("pend_cleared", pend, 0);
      strobe(1000, 1000, 1'b0);
      strobe(1000, 1000, 1'b0);

      // Saturation / wrap with full-scale data and coefficients
      for (int k = 0; k < TAPS; k++) write_shadow(k, 32767);
      swap_in();
      for (int n = 1; n <= 10; n++) begin
         e = sat_run(n, 1'b0);
         strobe(32767, e.mac, e.sat);
      end
      check("sat_pos_full", full, 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         e = sat_run(n, 1'b1);
         strobe(-32768, e.mac, e.sat);
      end

      // Reset mid-operation with a commit pending and a full pipeline
      write_shadow(0, 1);
      commit = 1'b1;
      tick();
      commit = 1'b0;
      check("pre_rst_pend", pend, 1);
      check("pre_rst_full", full, 1);
      rst = 1'b1; en = 1'b1; x = 16'sd1000; commit = 1'b1;
      tick();
      rst = 1'b0; en = 1'b0; x = '0; commit = 1'b0;
      check("midrst_mac", mac, 0);
      check("midrst_full", full, 0);
      check("midrst_sat", sat, 0);
      check("midrst_pend", pend, 0);
      strobe(1000, 0, 1'b0);
      check("post_rst_pend", pend, 0);

      tick();
      check("sb_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
